// File: rtl/cart_bus_mux_pkg.sv
// cart_bus_mux_pkg: shared types, constants and helpers for the cartridge bus concentrator.
package cart_bus_mux_pkg;
  typedef enum logic {IDLE, OWNED} arb_state_e;
  localparam logic [7:0] OPEN_BUS_RST = 8'h00;
  function automatic int unsigned popcount8(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin owner arbiter; an owner keeps the grant until its request drops.
module rr_arbiter
  import cart_bus_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic          owned_o,
  output logic [IW-1:0] idx_o
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, idx_q, idx_d, pick;
  logic [N-1:0] gnt_q, gnt_d;
  logic found;
  int c;
  always_comb begin
    found = 1'b0;
    pick = '0;
    c = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_q) + k) % N;
      if (!found && req_i[IW'(c)]) begin
        found = 1'b1;
        pick = IW'(c);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    idx_d = idx_q;
    gnt_d = gnt_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = OWNED;
        idx_d = pick;
        gnt_d = N'(1) << pick;
      end
    end else if (!req_i[idx_q]) begin
      state_d = IDLE;
      gnt_d = '0;
      last_d = idx_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(N - 1);
      idx_q <= '0;
      gnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
    end
  end
  assign gnt_o = gnt_q;
  assign owned_o = state_q == OWNED;
  assign idx_o = idx_q;
endmodule

// File: rtl/cart_bus_mux.sv
// cart_bus_mux: merges mapper read data with open-bus fallback, aggregates IRQs,
// tracks read-claim conflicts and shares the ROM port via a round-robin arbiter.
module cart_bus_mux
  import cart_bus_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic              CPURD_N,
  input  logic              CPUWR_N,
  input  logic              SYSCLKR_CE,
  input  logic [DW-1:0]     CPU_DO,
  output logic [DW-1:0]     CPU_DI,
  input  logic [NCH-1:0]    CH_SEL,
  input  logic [NCH*DW-1:0] CH_DO,
  input  logic [NCH-1:0]    CH_IRQ_N,
  input  logic [NCH-1:0]    IRQ_MASK,
  output logic              IRQ_N,
  output logic              CONFLICT,
  output logic [7:0]        CONFLICT_CNT,
  input  logic              CLR_CONFLICT,
  input  logic [NCH-1:0]    ROM_REQ,
  output logic [NCH-1:0]    ROM_GNT,
  input  logic [NCH*AW-1:0] CH_ROM_ADDR,
  input  logic [NCH-1:0]    CH_ROM_OE_N,
  output logic [AW-1:0]     ROM_ADDR,
  output logic              ROM_CE_N,
  output logic              ROM_OE_N
);
  localparam int IW = $clog2(NCH);
  logic [DW-1:0] open_bus_q, open_bus_d, cpu_di;
  logic [7:0] cnt_q, cnt_d;
  logic conflict_q, conflict_d, irq_n_q, irq_n_d, conflict_ev, owned;
  logic [AW-1:0] rom_addr_q, ch_addr;
  logic [IW-1:0] idx;
  always_comb begin
    cpu_di = open_bus_q;
    for (int i = NCH - 1; i >= 0; i--) if (CH_SEL[i]) cpu_di = CH_DO[i*DW +: DW];
  end
  assign conflict_ev = SYSCLKR_CE && !CPURD_N && popcount8(8'(CH_SEL)) >= 2;
  always_comb begin
    open_bus_d = !SYSCLKR_CE ? open_bus_q : !CPUWR_N ? CPU_DO : !CPURD_N ? cpu_di : open_bus_q;
    cnt_d = CLR_CONFLICT ? 8'd0 : (conflict_ev && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    conflict_d = CLR_CONFLICT ? 1'b0 : conflict_ev ? 1'b1 : conflict_q;
    irq_n_d = ~|(~CH_IRQ_N & IRQ_MASK);
  end
  rr_arbiter #(.N(NCH)) u_arb (
    .clk(MCLK),
    .rst(RESET),
    .req_i(ROM_REQ),
    .gnt_o(ROM_GNT),
    .owned_o(owned),
    .idx_o(idx)
  );
  assign ch_addr = CH_ROM_ADDR[idx*AW +: AW];
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      open_bus_q <= DW'(OPEN_BUS_RST);
      cnt_q <= '0;
      conflict_q <= 1'b0;
      irq_n_q <= 1'b1;
      rom_addr_q <= '0;
    end else begin
      open_bus_q <= open_bus_d;
      cnt_q <= cnt_d;
      conflict_q <= conflict_d;
      irq_n_q <= irq_n_d;
      rom_addr_q <= owned ? ch_addr : rom_addr_q;
    end
  end
  // The address follows the owner live and is parked on its last value when idle.
  assign ROM_ADDR = owned ? ch_addr : rom_addr_q;
  assign ROM_CE_N = ~owned;
  assign ROM_OE_N = owned ? CH_ROM_OE_N[idx] : 1'b1;
  assign CPU_DI = cpu_di;
  assign IRQ_N = irq_n_q;
  assign CONFLICT = conflict_q;
  assign CONFLICT_CNT = cnt_q;
endmodule

// File: tb/tb_cart_bus_mux.sv
// tb_cart_bus_mux: table-driven read-mux vectors plus directed conflict, IRQ and ROM arbitration sequences.
module tb_cart_bus_mux;
  logic MCLK = 1'b0, RESET, CPURD_N, CPUWR_N, SYSCLKR_CE, IRQ_N, CONFLICT, CLR_CONFLICT;
  logic ROM_CE_N, ROM_OE_N;
  logic [7:0] CPU_DO, CPU_DI, CONFLICT_CNT;
  logic [3:0] CH_SEL, CH_IRQ_N, IRQ_MASK, ROM_REQ, ROM_GNT, CH_ROM_OE_N;
  logic [31:0] CH_DO;
  logic [95:0] CH_ROM_ADDR;
  logic [23:0] ROM_ADDR;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [3:0] sel;
    logic rd_n, wr_n, ce;
    logic [7:0] wdata, exp_di;
  } vec_t;
  vec_t vt[11];
  logic [23:0] addr_tab[4];
  int ord[5];

  cart_bus_mux #(.NCH(4), .DW(8), .AW(24)) dut (
    .MCLK(MCLK), .RESET(RESET), .CPURD_N(CPURD_N), .CPUWR_N(CPUWR_N),
    .SYSCLKR_CE(SYSCLKR_CE), .CPU_DO(CPU_DO), .CPU_DI(CPU_DI), .CH_SEL(CH_SEL),
    .CH_DO(CH_DO), .CH_IRQ_N(CH_IRQ_N), .IRQ_MASK(IRQ_MASK), .IRQ_N(IRQ_N),
    .CONFLICT(CONFLICT), .CONFLICT_CNT(CONFLICT_CNT), .CLR_CONFLICT(CLR_CONFLICT),
    .ROM_REQ(ROM_REQ), .ROM_GNT(ROM_GNT), .CH_ROM_ADDR(CH_ROM_ADDR),
    .CH_ROM_OE_N(CH_ROM_OE_N), .ROM_ADDR(ROM_ADDR), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    vt[0]  = '{4'b0000, 1, 1, 0, 8'h00, 8'h00};
    vt[1]  = '{4'b0000, 1, 0, 1, 8'h5A, 8'h00};
    vt[2]  = '{4'b0000, 0, 1, 1, 8'h00, 8'h5A};
    vt[3]  = '{4'b0110, 0, 1, 0, 8'h00, 8'h11};
    vt[4]  = '{4'b1000, 1, 1, 0, 8'h00, 8'h33};
    vt[5]  = '{4'b0100, 0, 1, 1, 8'h00, 8'h22};
    vt[6]  = '{4'b0000, 1, 1, 1, 8'h00, 8'h22};
    vt[7]  = '{4'b0000, 0, 0, 1, 8'hC3, 8'h22};
    vt[8]  = '{4'b0000, 1, 1, 0, 8'h00, 8'hC3};
    vt[9]  = '{4'b1001, 1, 1, 0, 8'h00, 8'hA0};
    vt[10] = '{4'b0000, 0, 1, 0, 8'h00, 8'hC3};
    addr_tab = '{24'h0F0000, 24'h1A1111, 24'h2B2222, 24'h3C3333};
    ord = '{0, 1, 2, 3, 0};

    RESET = 1'b1; CPURD_N = 1'b1; CPUWR_N = 1'b1; SYSCLKR_CE = 1'b0; CPU_DO = 8'h00;
    CH_SEL = 4'b0000; CH_DO = 32'h33_22_11_A0; CH_IRQ_N = 4'b1111; IRQ_MASK = 4'b1111;
    CLR_CONFLICT = 1'b0; ROM_REQ = 4'b0000; CH_ROM_OE_N = 4'b0101;
    CH_ROM_ADDR = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    tick(); tick();
    RESET = 1'b0;
    tick();
    chk("rst_cpu_di", CPU_DI, 8'h00);
    chk("rst_conflict", CONFLICT, 0);
    chk("rst_cnt", CONFLICT_CNT, 0);
    chk("rst_irq_n", IRQ_N, 1);
    chk("rst_gnt", ROM_GNT, 0);
    chk("rst_ce_n", ROM_CE_N, 1);
    chk("rst_oe_n", ROM_OE_N, 1);
    chk("rst_addr", ROM_ADDR, 0);

    for (int i = 0; i < 11; i++) begin
      CH_SEL = vt[i].sel; CPURD_N = vt[i].rd_n; CPUWR_N = vt[i].wr_n;
      SYSCLKR_CE = vt[i].ce; CPU_DO = vt[i].wdata;
      #1;
      chk($sformatf("vec%0d_cpu_di", i), CPU_DI, vt[i].exp_di);
      tick();
      chk($sformatf("vec%0d_cnt", i), CONFLICT_CNT, 0);
    end

    CH_SEL = 4'b0110; CPURD_N = 1'b0; CPUWR_N = 1'b1; SYSCLKR_CE = 1'b1;
    #1;
    chk("conf_cpu_di", CPU_DI, 8'h11);
    tick();
    chk("conf_flag", CONFLICT, 1);
    chk("conf_cnt1", CONFLICT_CNT, 1);
    repeat (253) tick();
    chk("conf_cnt254", CONFLICT_CNT, 254);
    repeat (46) tick();
    chk("conf_cnt_sat", CONFLICT_CNT, 255);
    CLR_CONFLICT = 1'b1;
    tick();
    chk("conf_clr_cnt", CONFLICT_CNT, 0);
    chk("conf_clr_flag", CONFLICT, 0);
    CLR_CONFLICT = 1'b0; CH_SEL = 4'b0000; CPURD_N = 1'b1; SYSCLKR_CE = 1'b0;
    tick();

    CH_IRQ_N = 4'b1011; IRQ_MASK = 4'b1111;
    #1;
    chk("irq_latency", IRQ_N, 1);
    tick();
    chk("irq_assert", IRQ_N, 0);
    IRQ_MASK = 4'b1011;
    tick();
    chk("irq_masked", IRQ_N, 1);
    IRQ_MASK = 4'b0100;
    tick();
    chk("irq_only_ch2", IRQ_N, 0);
    CH_IRQ_N = 4'b1111;
    tick();
    chk("irq_release", IRQ_N, 1);

    ROM_REQ = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr%0d_gnt", i), ROM_GNT, 4'b0001 << ord[i]);
      chk($sformatf("rr%0d_addr", i), ROM_ADDR, addr_tab[ord[i]]);
      chk($sformatf("rr%0d_ce_n", i), ROM_CE_N, 0);
      chk($sformatf("rr%0d_oe_n", i), ROM_OE_N, CH_ROM_OE_N[ord[i]]);
      tick(); tick();
      chk($sformatf("rr%0d_hold", i), ROM_GNT, 4'b0001 << ord[i]);
      ROM_REQ[ord[i]] = 1'b0;
      tick();
      chk($sformatf("rr%0d_idle_gnt", i), ROM_GNT, 0);
      chk($sformatf("rr%0d_idle_ce_n", i), ROM_CE_N, 1);
      chk($sformatf("rr%0d_idle_oe_n", i), ROM_OE_N, 1);
      chk($sformatf("rr%0d_idle_addr", i), ROM_ADDR, addr_tab[ord[i]]);
      ROM_REQ[ord[i]] = 1'b1;
      tick();
    end
    ROM_REQ = 4'b0000;
    tick();

    ROM_REQ = 4'b0100;
    tick();
    chk("rstg_gnt2", ROM_GNT, 4'b0100);
    chk("rstg_ce_n0", ROM_CE_N, 0);
    #2 RESET = 1'b1;
    #1;
    chk("rstg_gnt", ROM_GNT, 0);
    chk("rstg_ce_n", ROM_CE_N, 1);
    chk("rstg_oe_n", ROM_OE_N, 1);
    chk("rstg_addr", ROM_ADDR, 0);
    #1 RESET = 1'b0;
    ROM_REQ = 4'b1111;
    tick();
    chk("rstg_first_ch0", ROM_GNT, 4'b0001);

    ROM_REQ = 4'b0000;
    tick();
    ROM_REQ = 4'b0010;
    tick();
    chk("wait_gnt1", ROM_GNT, 4'b0010);
    ROM_REQ = 4'b1010;
    tick();
    chk("wait_hold1a", ROM_GNT, 4'b0010);
    tick();
    chk("wait_hold1b", ROM_GNT, 4'b0010);
    ROM_REQ = 4'b1000;
    tick();
    chk("wait_gap", ROM_GNT, 4'b0000);
    tick();
    chk("wait_gnt3", ROM_GNT, 4'b1000);
    chk("wait_addr3", ROM_ADDR, addr_tab[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
